// File: rtl/manch_pkg.sv
// Shared definitions for the Manchester receive path: arbiter FSM state
// encodings, the default decoder byte width, and the channel-id width helper.
// Used by the decoder bank, the receive arbiter and the downstream frame logic.
package manch_pkg;

    localparam int unsigned DATA_BITS_DEF = 8;

    // Two legal states; the other two encodings are treated as corrupt.
    typedef enum logic [1:0] {
        IDLE_S = 2'b00,
        HOLD_S = 2'b01
    } state_e;

    // Channel-id width; at least one bit so single-channel builds still elaborate.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/manch_rx_arbiter_if.sv
// Merged output byte stream of the receive arbiter (valid/ready handshake).
//   out_valid  byte available
//   out_ready  downstream accepts the byte
//   out_data   granted byte
//   out_ch     source channel of out_data
// master: the arbiter side; slave: the downstream consumer.
interface manch_rx_arbiter_if
    import manch_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
) ();

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic [CH_W-1:0]      out_ch;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );

endinterface

// File: rtl/manch_rr_pick.sv
// Combinational round-robin picker.
//   req      request vector, one bit per channel
//   ptr      channel with highest priority this cycle
//   gnt      one-hot grant (zero when nothing requested)
//   gnt_idx  index of the granted channel
//   any_gnt  at least one request present
// Searches ptr, ptr+1, ... modulo NUM_CH and grants the first request found.
module manch_rr_pick
    import manch_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]           req,
    input  logic [ch_width(NUM_CH)-1:0] ptr,
    output logic [NUM_CH-1:0]           gnt,
    output logic [ch_width(NUM_CH)-1:0] gnt_idx,
    output logic                        any_gnt
);

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic [CH_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((32'(ptr) + 32'(i)) % NUM_CH);
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/manch_rx_arbiter.sv
// Merges the byte strobes of NUM_CH Manchester decoders into one valid/ready
// byte stream with round-robin arbitration.
//   clk, reset  system clock, asynchronous active-high reset
//   ch_strobe   one-cycle pulse per decoded byte, one bit per channel
//   ch_data     channel i byte at [i*DATA_BITS +: DATA_BITS], valid with its strobe
//   out_if      merged output stream (master side)
//   ovr_flag    sticky per-channel overrun (byte dropped, held byte kept)
//   ovr_clear   one-cycle clear of ovr_flag bits; a same-cycle overrun wins
//   busy        any holding buffer full or output valid
// Decoders cannot be stalled, so each channel owns a one-entry holding buffer.
module manch_rx_arbiter
    import manch_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_strobe,
    input  logic [NUM_CH*DATA_BITS-1:0]   ch_data,
    manch_rx_arbiter_if.master            out_if,
    output logic [NUM_CH-1:0]             ovr_flag,
    input  logic [NUM_CH-1:0]             ovr_clear,
    output logic                          busy
);

    localparam int unsigned CH_W = ch_width(NUM_CH);

    state_e               state_q, state_d;
    logic [NUM_CH-1:0]    buf_full_q, buf_full_d;
    logic [DATA_BITS-1:0] buf_data_q [NUM_CH];
    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [DATA_BITS-1:0] out_data_q;
    logic [CH_W-1:0]      out_ch_q;
    logic [NUM_CH-1:0]    ovr_q, ovr_d;

    logic                 out_valid;
    logic                 state_legal;
    logic                 out_free;
    logic                 grant;
    logic [NUM_CH-1:0]    gnt;
    logic [CH_W-1:0]      gnt_idx;
    logic                 any_gnt;
    logic [NUM_CH-1:0]    drain;
    logic [NUM_CH-1:0]    capture;
    logic [NUM_CH-1:0]    overrun;

    manch_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req     (buf_full_q),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // Grant and buffer bookkeeping.
    always_comb begin
        state_legal = (state_q == IDLE_S) || (state_q == HOLD_S);
        // Accepting the current byte frees the register in the same cycle.
        out_free    = !out_valid || out_if.out_ready;
        grant       = state_legal && out_free && any_gnt;
        drain       = gnt & {NUM_CH{grant}};
        // A buffer emptied into the output this cycle can take a new byte.
        capture     = ch_strobe & (~buf_full_q | drain);
        overrun     = ch_strobe & buf_full_q & ~drain;
        buf_full_d  = state_legal ? ((buf_full_q & ~drain) | capture) : '0;
        ovr_d       = (ovr_q & ~ovr_clear) | overrun;
        ptr_d       = ptr_q;
        if (grant) begin
            ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_q <= '0;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            ovr_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_full_q <= buf_full_d;
            ptr_q      <= ptr_d;
            ovr_q      <= ovr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture[i]) begin
                    buf_data_q[i] <= ch_data[i*DATA_BITS +: DATA_BITS];
                end
            end
            if (grant) begin
                out_data_q <= buf_data_q[gnt_idx];
                out_ch_q   <= gnt_idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_S;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_S: begin
                if (grant) state_d = HOLD_S;
            end
            HOLD_S: begin
                if (out_if.out_ready) state_d = grant ? HOLD_S : IDLE_S;
            end
            default: state_d = IDLE_S;
        endcase
    end

    // FSM and block outputs.
    always_comb begin
        out_valid        = (state_q == HOLD_S);
        out_if.out_valid = out_valid;
        out_if.out_data  = out_data_q;
        out_if.out_ch    = out_ch_q;
        ovr_flag         = ovr_q;
        busy             = (|buf_full_q) || out_valid;
    end

endmodule

// File: tb/tb_manch_rx_arbiter.sv
// Directed bench for manch_rx_arbiter (NUM_CH=4, DATA_BITS=8).
module tb_manch_rx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  ch_strobe;
    logic [31:0] ch_data;
    logic [3:0]  ovr_flag;
    logic [3:0]  ovr_clear;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    manch_rx_arbiter_if #(.NUM_CH(4), .DATA_BITS(8)) out_if ();

    manch_rx_arbiter #(
        .NUM_CH    (4),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_strobe (ch_strobe),
        .ch_data   (ch_data),
        .out_if    (out_if),
        .ovr_flag  (ovr_flag),
        .ovr_clear (ovr_clear),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [7:0] val);
        ch_strobe          = 4'b0001 << ch;
        ch_data[ch*8 +: 8] = val;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] data, input logic [1:0] ch);
        check_eq({tag, "_valid"}, 32'(out_if.out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(out_if.out_data), 32'(data));
        check_eq({tag, "_ch"}, 32'(out_if.out_ch), 32'(ch));
    endtask

    initial begin
        reset            = 1'b1;
        ch_strobe        = '0;
        ch_data          = '0;
        ovr_clear        = '0;
        out_if.out_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", 32'(out_if.out_valid), 32'd0);
        check_eq("rst_data", 32'(out_if.out_data), 32'd0);
        check_eq("rst_ch", 32'(out_if.out_ch), 32'd0);
        check_eq("rst_ovr", 32'(ovr_flag), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Single byte on ch2: buffer at t+1, output at t+2, gone at t+3.
        put(2, 8'hA5);
        tick();
        ch_strobe = '0;
        check_eq("single_t1_valid", 32'(out_if.out_valid), 32'd0);
        check_eq("single_t1_busy", 32'(busy), 32'd1);
        tick();
        expect_out("single_t2", 8'hA5, 2'd2);
        tick();
        check_eq("single_t3_valid", 32'(out_if.out_valid), 32'd0);
        check_eq("single_t3_busy", 32'(busy), 32'd0);
        check_eq("single_ovr", 32'(ovr_flag), 32'd0);

        // Fresh pointer for the fairness pass.
        reset = 1'b1;
        tick();
        reset = 1'b0;

        ch_strobe = 4'hF;
        ch_data   = 32'h1312_1110;
        tick();
        ch_strobe = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("fair%0d", k), 8'(8'h10 + k), 2'(k));
            tick();
        end
        check_eq("fair_end_valid", 32'(out_if.out_valid), 32'd0);

        // Pointer 0 -> grant ch1 -> pointer 2; then ch0+ch3 together.
        put(1, 8'h21);
        tick();
        ch_strobe = '0;
        tick();
        expect_out("rot_pre", 8'h21, 2'd1);
        tick();
        ch_strobe = 4'b1001;
        ch_data[7:0]   = 8'h30;
        ch_data[31:24] = 8'h33;
        tick();
        ch_strobe = '0;
        tick();
        expect_out("rot_first", 8'h33, 2'd3);
        tick();
        expect_out("rot_second", 8'h30, 2'd0);
        tick();
        check_eq("rot_end_valid", 32'(out_if.out_valid), 32'd0);

        // Backpressure with a stalled buffer and an overrun on ch1.
        out_if.out_ready = 1'b0;
        put(1, 8'h5A);
        tick();
        ch_strobe = '0;
        tick();
        expect_out("bp_start", 8'h5A, 2'd1);
        for (int k = 0; k < 10; k++) begin
            ch_strobe = '0;
            if (k == 2) put(1, 8'h5B);
            if (k == 5) put(1, 8'h5C);
            tick();
            expect_out($sformatf("bp_hold%0d", k), 8'h5A, 2'd1);
            if (k == 4) check_eq("bp_ovr_before", 32'(ovr_flag), 32'd0);
        end
        ch_strobe = '0;
        check_eq("bp_ovr_set", 32'(ovr_flag), 32'h2);
        out_if.out_ready = 1'b1;
        tick();
        expect_out("bp_retained", 8'h5B, 2'd1);
        tick();
        check_eq("bp_end_valid", 32'(out_if.out_valid), 32'd0);
        check_eq("bp_end_busy", 32'(busy), 32'd0);
        check_eq("bp_ovr_sticky", 32'(ovr_flag), 32'h2);

        // ch0 buffer drains into the output while a new ch0 byte arrives.
        out_if.out_ready = 1'b0;
        put(0, 8'h70);
        tick();
        ch_strobe = '0;
        tick();
        expect_out("refill_hold", 8'h70, 2'd0);
        put(0, 8'h71);
        tick();
        out_if.out_ready = 1'b1;
        put(0, 8'h77);
        tick();
        ch_strobe = '0;
        expect_out("refill_drain", 8'h71, 2'd0);
        check_eq("refill_no_ovr", 32'(ovr_flag), 32'h2);
        tick();
        expect_out("refill_new", 8'h77, 2'd0);
        tick();
        check_eq("refill_end_valid", 32'(out_if.out_valid), 32'd0);

        // Overrun on ch1 in the same cycle as its clear: set wins.
        out_if.out_ready = 1'b0;
        put(1, 8'h80);
        tick();
        ch_strobe = '0;
        tick();
        expect_out("clr_hold", 8'h80, 2'd1);
        put(1, 8'h81);
        tick();
        put(1, 8'h82);
        ovr_clear = 4'b0010;
        tick();
        ch_strobe = '0;
        ovr_clear = '0;
        check_eq("clr_set_wins", 32'(ovr_flag), 32'h2);
        ovr_clear = 4'b0010;
        tick();
        ovr_clear = '0;
        check_eq("clr_cleared", 32'(ovr_flag), 32'h0);
        check_eq("clr_data_held", 32'(out_if.out_data), 32'h80);

        // Asynchronous reset with output valid and buffers 1..3 full.
        ch_strobe = 4'b1100;
        ch_data[23:16] = 8'h90;
        ch_data[31:24] = 8'h91;
        tick();
        ch_strobe = '0;
        check_eq("mid_pre_valid", 32'(out_if.out_valid), 32'd1);
        check_eq("mid_pre_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_if.out_valid), 32'd0);
        check_eq("mid_rst_data", 32'(out_if.out_data), 32'd0);
        check_eq("mid_rst_ch", 32'(out_if.out_ch), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ovr", 32'(ovr_flag), 32'd0);
        #1 reset = 1'b0;
        out_if.out_ready = 1'b1;
        put(3, 8'hC3);
        tick();
        ch_strobe = '0;
        check_eq("post_t1_valid", 32'(out_if.out_valid), 32'd0);
        tick();
        expect_out("post_t2", 8'hC3, 2'd3);
        tick();
        check_eq("post_t3_valid", 32'(out_if.out_valid), 32'd0);
        check_eq("post_t3_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
